branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side bimodal branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters.
- Predicts next-PC direction and target for the fetch PC in the same cycle.
- Consumes branch resolution results from the execute stage (pc, irregPc, isBranch, isBranchTaken, branchPredict), updates its tables on the following clock edge, and flags mispredictions with a recovery PC.
- Keeps branch and mispredict performance counters.

Parameters:
- PC_WIDTH, 32, width of PC and targets.
- ENTRY_NUM, 64, BTB/counter entries; power of two ≥ 2.
- INDEX_BITS, $clog2(ENTRY_NUM), derived; index = pc[INDEX_BITS+1:2].
- TAG_BITS, PC_WIDTH-INDEX_BITS-2, derived; tag = pc[PC_WIDTH-1:INDEX_BITS+2].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high (matched against RESET).
- fetch_pc  in  PC_WIDTH  PC being fetched this cycle.
- pred_taken  out  1  predicted taken for fetch_pc.
- pred_target  out  PC_WIDTH  predicted next PC: BTB target if pred_taken, else fetch_pc+4.
- resolve_valid  in  1  resolution inputs valid; asserted exactly one cycle per retiring instruction, low for bubbles and stalls.
- resolve_pc  in  PC_WIDTH  PC of resolved instruction.
- resolve_is_branch  in  1  instruction is branch/jump.
- resolve_taken  in  1  actual direction.
- resolve_target  in  PC_WIDTH  actual taken target (irregPc).
- resolve_pred_taken  in  1  prediction carried down the pipe.
- resolve_pred_target  in  PC_WIDTH  predicted next PC carried down the pipe.
- mispredict  out  1  combinational mispredict flag.
- recovery_pc  out  PC_WIDTH  correct next PC when mispredict=1.
- branch_count  out  32  resolved branches since reset.
- mispredict_count  out  32  mispredicts since reset.

Behaviour:
- Reset (async, rst=1):
  - All valid bits cleared; all counters set to 01 (weakly not-taken); tags and targets set to 0; both perf counters set to 0.
  - Outputs during and after reset: pred_taken=0, pred_target=fetch_pc+4, mispredict=0 while resolve_valid=0.
- Prediction is purely combinational, zero latency:
  - hit = valid[idx] && tag[idx]==tag(fetch_pc).
  - pred_taken = hit && ctr[idx][1].
- Read/write same index in the same cycle: the prediction uses the pre-update contents; no bypass.
- Mispredict (combinational, only when resolve_valid=1):
  - Branch: actual next = resolve_taken ? resolve_target : resolve_pc+4. mispredict = (actual next != resolve_pred_target) || (resolve_taken != resolve_pred_taken).
  - Non-branch: mispredict = resolve_pred_taken; recovery_pc = resolve_pc+4.
  - recovery_pc = actual next. When mispredict=0, recovery_pc is don't-care but driven as actual next.
- Table update at the posedge where resolve_valid=1, using rhit = hit lookup on resolve_pc:
  - Branch taken, rhit: ctr increments, saturating at 11; target overwritten with resolve_target.
  - Branch taken, miss: allocate (valid=1, tag, target), ctr=10.
  - Branch not taken, rhit: ctr decrements, saturating at 00; entry stays valid.
  - Branch not taken, miss: no change.
  - Non-branch, rhit: valid cleared (alias eviction). Non-branch, miss: no change.
- Perf counters on the same edge:
  - branch_count +1 per valid branch.
  - mispredict_count +1 per valid mispredict.
  - Both wrap modulo 2^32.
- resolve_valid=0: no state changes.
- rst asserted mid-operation: state returns to reset values immediately, regardless of clk.
- PC arithmetic (+4) wraps modulo 2^PC_WIDTH; PC bits [1:0] are ignored for index and tag.

Decomposition:
- Package BranchPredictorTypes:
  - PhtCounter (2-bit) with constants STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - BtbEntry struct {valid, tag, target}.
  - BranchPredict struct {predTaken, predTarget} carried through pipeline regs.
  - Functions for index/tag extraction.
- One sub-module, bp_table: ENTRY_NUM-deep flop array holding BtbEntry + PhtCounter, with one combinational read port (fetch), one combinational lookup port (resolve), one write port, and async reset.

Test Plan:
- Reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; both counters 0.
- Resolve taken branch pc=0x100, target=0x200, pred_taken=0, pred_target=0x104 -> mispredict=1, recovery_pc=0x200. Next cycle fetch 0x100 -> pred_taken=1, pred_target=0x200; branch_count=1, mispredict_count=1.
- Saturation: same branch resolved taken 3 more times (ctr 10→11→11), then not-taken twice -> ctr 01, pred_taken=0, entry still valid; third not-taken -> ctr 00, stays 00.
- Alias: non-branch pc=0x100 resolved with pred_taken=1, pred_target=0x200 -> mispredict=1, recovery_pc=0x104; next cycle fetch 0x100 -> pred_taken=0.
- Same-cycle: fetch_pc=0x300 while first taken resolve of 0x300 -> pred_taken=0 in that cycle, 1 in the next. resolve_valid=0 with garbage inputs -> no state change, mispredict=0.
- Async reset asserted mid-cycle after training -> pred_taken drops to 0 without a clock edge; counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared widths, table entry types and index/tag helpers for the bimodal
// branch predictor and its BTB/counter table.
package branch_predictor_pkg;

   localparam int unsigned PC_WIDTH   = 32;
   localparam int unsigned ENTRY_NUM  = 64;
   localparam int unsigned INDEX_BITS = $clog2(ENTRY_NUM);
   localparam int unsigned TAG_BITS   = PC_WIDTH - INDEX_BITS - 2;

   // 2-bit saturating direction counter
   typedef logic [1:0] pht_counter_t;
   localparam pht_counter_t STRONG_NT = 2'b00;
   localparam pht_counter_t WEAK_NT   = 2'b01;
   localparam pht_counter_t WEAK_T    = 2'b10;
   localparam pht_counter_t STRONG_T  = 2'b11;

   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [PC_WIDTH-1:0] target;
   } btb_entry_t;

   // Prediction carried down the pipeline alongside the instruction
   typedef struct packed {
      logic                pred_taken;
      logic [PC_WIDTH-1:0] pred_target;
   } branch_predict_t;

   function automatic logic [INDEX_BITS-1:0] pc_index(input logic [PC_WIDTH-1:0] pc);
      return pc[INDEX_BITS+1:2];
   endfunction

   function automatic logic [TAG_BITS-1:0] pc_tag(input logic [PC_WIDTH-1:0] pc);
      return pc[PC_WIDTH-1:INDEX_BITS+2];
   endfunction

   function automatic pht_counter_t ctr_inc(input pht_counter_t c);
      return (c == STRONG_T) ? c : pht_counter_t'(c + 2'd1);
   endfunction

   function automatic pht_counter_t ctr_dec(input pht_counter_t c);
      return (c == STRONG_NT) ? c : pht_counter_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// bp_table: direct-mapped BTB entries plus 2-bit counters held in flops.
// Ports: clk/rst (async, active-high); rd_* combinational fetch read port;
// lk_* combinational resolve lookup port; we/wr_* single write port.
module bp_table
   import branch_predictor_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output btb_entry_t            rd_entry,
   output pht_counter_t          rd_ctr,
   input  logic [INDEX_BITS-1:0] lk_idx,
   output btb_entry_t            lk_entry,
   output pht_counter_t          lk_ctr,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  btb_entry_t            wr_entry,
   input  pht_counter_t          wr_ctr
);

   btb_entry_t   entries [ENTRY_NUM];
   pht_counter_t ctrs    [ENTRY_NUM];

   // Table storage; reset leaves every entry invalid and weakly not-taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            entries[i] <= '0;
            ctrs[i]    <= WEAK_NT;
         end
      end else if (we) begin
         entries[wr_idx] <= wr_entry;
         ctrs[wr_idx]    <= wr_ctr;
      end
   end

   // Reads return pre-write contents: no bypass from the write port
   assign rd_entry = entries[rd_idx];
   assign rd_ctr   = ctrs[rd_idx];
   assign lk_entry = entries[lk_idx];
   assign lk_ctr   = ctrs[lk_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side bimodal predictor with direct-mapped BTB.
// Ports: clk, rst (async, active-high); fetch_pc -> pred_taken/pred_target
// (combinational); resolve_* from execute -> mispredict/recovery_pc
// (combinational) and table update on the next edge; branch_count and
// mispredict_count performance counters.
module branch_predictor
   import branch_predictor_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_WIDTH-1:0] fetch_pc,
   output logic                pred_taken,
   output logic [PC_WIDTH-1:0] pred_target,
   input  logic                resolve_valid,
   input  logic [PC_WIDTH-1:0] resolve_pc,
   input  logic                resolve_is_branch,
   input  logic                resolve_taken,
   input  logic [PC_WIDTH-1:0] resolve_target,
   input  logic                resolve_pred_taken,
   input  logic [PC_WIDTH-1:0] resolve_pred_target,
   output logic                mispredict,
   output logic [PC_WIDTH-1:0] recovery_pc,
   output logic [31:0]         branch_count,
   output logic [31:0]         mispredict_count
);

   btb_entry_t      rd_entry, lk_entry, wr_entry;
   pht_counter_t    rd_ctr, lk_ctr, wr_ctr;
   logic            we;
   logic            fetch_hit, resolve_hit;
   logic [PC_WIDTH-1:0] actual_next;
   branch_predict_t pred;

   bp_table u_table (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (pc_index(fetch_pc)),
      .rd_entry (rd_entry),
      .rd_ctr   (rd_ctr),
      .lk_idx   (pc_index(resolve_pc)),
      .lk_entry (lk_entry),
      .lk_ctr   (lk_ctr),
      .we       (we),
      .wr_idx   (pc_index(resolve_pc)),
      .wr_entry (wr_entry),
      .wr_ctr   (wr_ctr)
   );

   // Fetch-side prediction
   always_comb begin
      fetch_hit        = rd_entry.valid && (rd_entry.tag == pc_tag(fetch_pc));
      pred.pred_taken  = fetch_hit && rd_ctr[1];
      pred.pred_target = pred.pred_taken ? rd_entry.target : fetch_pc + PC_WIDTH'(4);
   end

   assign pred_taken  = pred.pred_taken;
   assign pred_target = pred.pred_target;

   // Resolution check: compare actual outcome with the carried prediction
   always_comb begin
      resolve_hit = lk_entry.valid && (lk_entry.tag == pc_tag(resolve_pc));
      actual_next = (resolve_is_branch && resolve_taken) ? resolve_target
                                                         : resolve_pc + PC_WIDTH'(4);
      mispredict  = 1'b0;
      if (resolve_valid) begin
         if (resolve_is_branch) begin
            mispredict = (actual_next != resolve_pred_target) ||
                         (resolve_taken != resolve_pred_taken);
         end else begin
            mispredict = resolve_pred_taken;
         end
      end
   end

   assign recovery_pc = actual_next;

   // Table write decision for the resolved instruction
   always_comb begin
      we       = 1'b0;
      wr_entry = lk_entry;
      wr_ctr   = lk_ctr;
      if (resolve_valid) begin
         if (resolve_is_branch && resolve_taken) begin
            we = 1'b1;
            if (resolve_hit) begin
               wr_ctr          = ctr_inc(lk_ctr);
               wr_entry.target = resolve_target;
            end else begin
               wr_entry.valid  = 1'b1;
               wr_entry.tag    = pc_tag(resolve_pc);
               wr_entry.target = resolve_target;
               wr_ctr          = WEAK_T;
            end
         end else if (resolve_is_branch) begin
            if (resolve_hit) begin
               we     = 1'b1;
               wr_ctr = ctr_dec(lk_ctr);
            end
         end else if (resolve_hit) begin
            // A non-branch hitting the BTB is an alias; drop the entry
            we             = 1'b1;
            wr_entry.valid = 1'b0;
         end
      end
   end

   // Performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (resolve_valid) begin
         if (resolve_is_branch) branch_count <= branch_count + 32'd1;
         if (mispredict)        mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a reference model computes the
// expected prediction/mispredict/counters per cycle into a scoreboard queue.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        resolve_valid;
   logic [31:0] resolve_pc;
   logic        resolve_is_branch;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        resolve_pred_taken;
   logic [31:0] resolve_pred_target;
   logic        mispredict;
   logic [31:0] recovery_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   branch_predictor dut (
      .clk                 (clk),
      .rst                 (rst),
      .fetch_pc            (fetch_pc),
      .pred_taken          (pred_taken),
      .pred_target         (pred_target),
      .resolve_valid       (resolve_valid),
      .resolve_pc          (resolve_pc),
      .resolve_is_branch   (resolve_is_branch),
      .resolve_taken       (resolve_taken),
      .resolve_target      (resolve_target),
      .resolve_pred_taken  (resolve_pred_taken),
      .resolve_pred_target (resolve_pred_target),
      .mispredict          (mispredict),
      .recovery_pc         (recovery_pc),
      .branch_count        (branch_count),
      .mispredict_count    (mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        pt;
      logic [31:0] ptg;
      logic        mp;
      logic [31:0] rec;
      logic        chk_rec;
      logic [31:0] bc;
      logic [31:0] mc;
   } rec_t;

   rec_t sb[$];
   rec_t obs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state (64 entries, index pc[7:2], tag pc[31:8])
   logic        m_valid [64];
   logic [23:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   logic [1:0]  m_ctr   [64];
   logic [31:0] m_bc, m_mc;

   task automatic m_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
      end
      m_bc = '0; m_mc = '0;
   endtask

   function automatic logic m_hit(input logic [31:0] pc);
      int i = int'(pc[7:2]);
      return m_valid[i] && (m_tag[i] == pc[31:8]);
   endfunction

   function automatic logic m_pt(input logic [31:0] pc);
      int i = int'(pc[7:2]);
      return m_hit(pc) && m_ctr[i][1];
   endfunction

   function automatic logic [31:0] m_ptg(input logic [31:0] pc);
      int i = int'(pc[7:2]);
      return m_pt(pc) ? m_tgt[i] : pc + 32'd4;
   endfunction

   // Drive one cycle at the negedge, push model expectation, capture outputs
   task automatic drive(input logic [31:0] fpc, input logic rv, input logic [31:0] rpc,
                        input logic isb, input logic tk, input logic [31:0] tgt,
                        input logic use_model, input logic rpt_in, input logic [31:0] rptg_in,
                        input string tag);
      rec_t        e, o;
      logic        rpt, h;
      logic [31:0] rptg, nxt;
      int          i;
      @(negedge clk);
      rpt  = use_model ? m_pt(rpc)  : rpt_in;
      rptg = use_model ? m_ptg(rpc) : rptg_in;
      fetch_pc = fpc; resolve_valid = rv; resolve_pc = rpc; resolve_is_branch = isb;
      resolve_taken = tk; resolve_target = tgt;
      resolve_pred_taken = rpt; resolve_pred_target = rptg;
      nxt       = (isb && tk) ? tgt : rpc + 32'd4;
      e.tag     = tag;
      e.pt      = m_pt(fpc);
      e.ptg     = m_ptg(fpc);
      e.mp      = rv && (isb ? ((nxt != rptg) || (tk != rpt)) : rpt);
      e.rec     = nxt;
      e.chk_rec = rv;
      e.bc      = m_bc;
      e.mc      = m_mc;
      sb.push_back(e);
      if (rv) begin
         i = int'(rpc[7:2]);
         h = m_hit(rpc);
         if (isb)  m_bc = m_bc + 32'd1;
         if (e.mp) m_mc = m_mc + 32'd1;
         if (isb && tk) begin
            if (h) begin
               if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
               m_tgt[i] = tgt;
            end else begin
               m_valid[i] = 1'b1; m_tag[i] = rpc[31:8]; m_tgt[i] = tgt; m_ctr[i] = 2'b10;
            end
         end else if (isb) begin
            if (h && m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'd1;
         end else if (h) begin
            m_valid[i] = 1'b0;
         end
      end
      #1;
      o       = e;
      o.pt    = pred_taken;
      o.ptg   = pred_target;
      o.mp    = mispredict;
      o.rec   = recovery_pc;
      o.bc    = branch_count;
      o.mc    = mispredict_count;
      obs.push_back(o);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fetch_pc = 32'h100; resolve_valid = 1'b0; resolve_pc = '0; resolve_is_branch = 1'b0;
      resolve_taken = 1'b0; resolve_target = '0; resolve_pred_taken = 1'b0;
      resolve_pred_target = '0;
      m_reset();
      #1;
      n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset pred_taken: got %0b expected 0", pred_taken); end
      n_checks++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset pred_target: got %h expected 00000104", pred_target); end
      n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset mispredict: got %0b expected 0", mispredict); end
      n_checks++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
         n_fail++; $display("FAIL reset counters: got %0d/%0d expected 0/0", branch_count, mispredict_count); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_train();
      rec_t e, o;
      drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h104, "train_first");
      drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "train_after");
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.ptg !== e.ptg) begin n_fail++; $display("FAIL %s pred_target: got %h expected %h", e.tag, o.ptg, e.ptg); end
         n_checks++; if (o.mp !== e.mp) begin n_fail++; $display("FAIL %s mispredict: got %0b expected %0b", e.tag, o.mp, e.mp); end
         if (e.chk_rec) begin
            n_checks++; if (o.rec !== e.rec) begin n_fail++; $display("FAIL %s recovery_pc: got %h expected %h", e.tag, o.rec, e.rec); end
         end
         n_checks++; if (o.bc !== e.bc || o.mc !== e.mc) begin
            n_fail++; $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", e.tag, o.bc, o.mc, e.bc, e.mc); end
      end
   endtask

   task automatic test_saturation();
      rec_t e, o;
      for (int k = 0; k < 3; k++)
         drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, "sat_taken");
      for (int k = 0; k < 3; k++)
         drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, "sat_not_taken");
      // From counter 00 a valid entry climbs to 01 then 10; an invalid one would jump to 10
      drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, "sat_retrain1");
      drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, "sat_retrain2");
      drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "sat_final");
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.ptg !== e.ptg) begin n_fail++; $display("FAIL %s pred_target: got %h expected %h", e.tag, o.ptg, e.ptg); end
         n_checks++; if (o.mp !== e.mp) begin n_fail++; $display("FAIL %s mispredict: got %0b expected %0b", e.tag, o.mp, e.mp); end
         n_checks++; if (o.bc !== e.bc || o.mc !== e.mc) begin
            n_fail++; $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", e.tag, o.bc, o.mc, e.bc, e.mc); end
      end
   endtask

   task automatic test_alias();
      rec_t e, o;
      drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, "alias_nonbranch");
      drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "alias_after");
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.mp !== e.mp) begin n_fail++; $display("FAIL %s mispredict: got %0b expected %0b", e.tag, o.mp, e.mp); end
         if (e.chk_rec) begin
            n_checks++; if (o.rec !== e.rec) begin n_fail++; $display("FAIL %s recovery_pc: got %h expected %h", e.tag, o.rec, e.rec); end
         end
      end
   endtask

   task automatic test_same_cycle();
      rec_t e, o;
      drive(32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h304, "same_cycle_write");
      drive(32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "same_cycle_next");
      drive(32'h300, 1'b0, $urandom, 1'b1, 1'b1, $urandom, 1'b0, 1'b1, $urandom, "idle_garbage");
      drive(32'h300, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, "idle_nonbranch");
      drive(32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "idle_after");
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.ptg !== e.ptg) begin n_fail++; $display("FAIL %s pred_target: got %h expected %h", e.tag, o.ptg, e.ptg); end
         n_checks++; if (o.mp !== e.mp) begin n_fail++; $display("FAIL %s mispredict: got %0b expected %0b", e.tag, o.mp, e.mp); end
         n_checks++; if (o.bc !== e.bc || o.mc !== e.mc) begin
            n_fail++; $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", e.tag, o.bc, o.mc, e.bc, e.mc); end
      end
   endtask

   task automatic test_back_to_back();
      rec_t        e, o;
      logic [31:0] pcs [6];
      logic [31:0] tgts [4];
      pcs[0] = 32'h100; pcs[1] = 32'h300; pcs[2] = 32'h104;
      pcs[3] = 32'h1000_0104; pcs[4] = 32'hFFFF_FFFC; pcs[5] = 32'h20;
      tgts[0] = 32'h800; tgts[1] = 32'h0; tgts[2] = 32'hFFFF_FFFC; tgts[3] = 32'h104;
      for (int k = 0; k < 60; k++) begin
         drive(pcs[$urandom_range(0, 5)], ($urandom_range(0, 3) != 0),
               pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 3) != 0),
               1'($urandom), tgts[$urandom_range(0, 3)],
               ($urandom_range(0, 2) != 0), 1'($urandom), tgts[$urandom_range(0, 3)],
               "back_to_back");
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.ptg !== e.ptg) begin n_fail++; $display("FAIL %s pred_target: got %h expected %h", e.tag, o.ptg, e.ptg); end
         n_checks++; if (o.mp !== e.mp) begin n_fail++; $display("FAIL %s mispredict: got %0b expected %0b", e.tag, o.mp, e.mp); end
         if (e.chk_rec) begin
            n_checks++; if (o.rec !== e.rec) begin n_fail++; $display("FAIL %s recovery_pc: got %h expected %h", e.tag, o.rec, e.rec); end
         end
         n_checks++; if (o.bc !== e.bc || o.mc !== e.mc) begin
            n_fail++; $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", e.tag, o.bc, o.mc, e.bc, e.mc); end
      end
   endtask

   task automatic test_async_reset();
      rec_t e, o;
      drive(32'h500, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0, "async_train");
      drive(32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "async_trained");
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.ptg !== e.ptg) begin n_fail++; $display("FAIL %s pred_target: got %h expected %h", e.tag, o.ptg, e.ptg); end
      end
      // Assert reset between clock edges; outputs must respond without a clock
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_reset pred_taken: got %0b expected 0", pred_taken); end
      n_checks++; if (pred_target !== 32'h504) begin n_fail++; $display("FAIL async_reset pred_target: got %h expected 00000504", pred_target); end
      n_checks++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
         n_fail++; $display("FAIL async_reset counters: got %0d/%0d expected 0/0", branch_count, mispredict_count); end
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      drive(32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "async_released");
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         n_checks++; if (o.pt !== e.pt) begin n_fail++; $display("FAIL %s pred_taken: got %0b expected %0b", e.tag, o.pt, e.pt); end
         n_checks++; if (o.bc !== e.bc || o.mc !== e.mc) begin
            n_fail++; $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", e.tag, o.bc, o.mc, e.bc, e.mc); end
      end
   endtask

   initial begin
      test_reset();
      test_train();
      test_saturation();
      test_alias();
      test_same_cycle();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
